// File: rtl/bus_slave_resp_pkg.sv
// rtl/bus_slave_resp_pkg.sv - shared bus constants and responder state encoding
// Purpose: word/address widths, READ/WRITE and active-low enable encodings,
//          wait-counter limits and the responder FSM state type.
// Ports:   none (package).
package bus_slave_resp_pkg;

  localparam int WORD_DATA_W = 32;
  localparam int WORD_ADDR_W = 30;

  localparam logic READ  = 1'b1;
  localparam logic WRITE = 1'b0;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int CNT_W    = 4;
  localparam int MAX_WAIT = 15;

  typedef enum logic [1:0] {
    BUS_SLV_IDLE   = 2'd0,
    BUS_SLV_ACCESS = 2'd1,
    BUS_SLV_ACK    = 2'd2
  } bus_slv_state_e;

endpackage

// File: rtl/bus_slave_bank.sv
// rtl/bus_slave_bank.sv - DEPTH x 32 register bank, one sync write, one async read
// Purpose: local word storage for the bus responder; contents are not reset.
// Ports:   clk       - clock
//          i_we      - write enable, commits on the rising edge
//          i_idx     - word index shared by the write and read ports
//          i_wr_data - write data
//          o_rd_data - combinational read of the addressed word
module bus_slave_bank
  import bus_slave_resp_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   i_we,
  input  logic [IDX_W-1:0]       i_idx,
  input  logic [WORD_DATA_W-1:0] i_wr_data,
  output logic [WORD_DATA_W-1:0] o_rd_data
);

  logic [WORD_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_idx] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_idx];

endmodule

// File: rtl/bus_slave_resp.sv
// rtl/bus_slave_resp.sv - bus responder with programmable wait states and local bank
// Purpose: accepts a request on chip-select plus address strobe, waits WAIT_CYCLES,
//          then pulses s_rdy_ low for one cycle, serving reads/writes from the bank.
// Ports:   clk, reset          - clock, synchronous active-high reset
//          s_cs_, s_as_        - chip select / address strobe, active-low
//          s_rw                - 1 = read, 0 = write
//          s_addr, s_wr_data   - word address and write data (latched on accept)
//          s_rd_data           - read data, zero whenever s_rdy_ is high
//          s_rdy_              - one-cycle active-low acknowledge
//          busy                - high while in ACCESS or ACK
module bus_slave_resp
  import bus_slave_resp_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   s_cs_,
  input  logic                   s_as_,
  input  logic                   s_rw,
  input  logic [WORD_ADDR_W-1:0] s_addr,
  input  logic [WORD_DATA_W-1:0] s_wr_data,
  output logic [WORD_DATA_W-1:0] s_rd_data,
  output logic                   s_rdy_,
  output logic                   busy
);

  localparam int              IDX_W   = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  generate
    if (WAIT_CYCLES < 0 || WAIT_CYCLES > MAX_WAIT) begin : g_bad_wait
      $error("bus_slave_resp: WAIT_CYCLES must be within 0..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("bus_slave_resp: DEPTH must be a power of two >= 2");
    end
  endgenerate

  bus_slv_state_e         r_state, w_state_nx;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nx;
  logic [IDX_W-1:0]       r_idx, w_idx_nx;
  logic                   r_rw, w_rw_nx;
  logic [WORD_DATA_W-1:0] r_wdata, w_wdata_nx;
  logic                   r_rdy_, w_rdy_nx;
  logic [WORD_DATA_W-1:0] r_rd_data, w_rd_data_nx;
  logic                   w_req;
  logic                   w_bank_we;
  logic [WORD_DATA_W-1:0] w_bank_rd;
  logic                   w_unused_addr_hi;

  // Upper address bits alias onto the bank and are deliberately dropped.
  assign w_unused_addr_hi = ^s_addr[WORD_ADDR_W-1:IDX_W];

  assign w_req = (s_cs_ == ENABLE_) && (s_as_ == ENABLE_);

  bus_slave_bank #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk       (clk),
    .i_we      (w_bank_we),
    .i_idx     (r_idx),
    .i_wr_data (r_wdata),
    .o_rd_data (w_bank_rd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= BUS_SLV_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_rw      <= READ;
      r_wdata   <= '0;
      r_rdy_    <= DISABLE_;
      r_rd_data <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_idx     <= w_idx_nx;
      r_rw      <= w_rw_nx;
      r_wdata   <= w_wdata_nx;
      r_rdy_    <= w_rdy_nx;
      r_rd_data <= w_rd_data_nx;
    end
  end

  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_idx_nx     = r_idx;
    w_rw_nx      = r_rw;
    w_wdata_nx   = r_wdata;
    w_rdy_nx     = DISABLE_;
    w_rd_data_nx = '0;
    w_bank_we    = 1'b0;
    case (r_state)
      BUS_SLV_IDLE: begin
        if (w_req) begin
          w_idx_nx   = s_addr[IDX_W-1:0];
          w_rw_nx    = s_rw;
          w_wdata_nx = s_wr_data;
          w_cnt_nx   = WAIT_LD;
          w_state_nx = BUS_SLV_ACCESS;
        end
      end
      BUS_SLV_ACCESS: begin
        if (!w_req) begin
          w_state_nx = BUS_SLV_IDLE;
        end else if (r_cnt == '0) begin
          // Outputs are loaded here so they are registered while in ACK.
          w_state_nx   = BUS_SLV_ACK;
          w_rdy_nx     = ENABLE_;
          w_rd_data_nx = (r_rw == READ) ? w_bank_rd : '0;
        end else begin
          w_cnt_nx = r_cnt - 1'b1;
        end
      end
      BUS_SLV_ACK: begin
        w_state_nx = BUS_SLV_IDLE;
        // A reset landing on the ACK cycle must drop the write too.
        w_bank_we  = (r_rw == WRITE) && !reset;
      end
      default: w_state_nx = BUS_SLV_IDLE;
    endcase
  end

  assign s_rdy_    = r_rdy_;
  assign s_rd_data = r_rd_data;
  assign busy      = (r_state == BUS_SLV_ACCESS) || (r_state == BUS_SLV_ACK);

endmodule

// File: tb/tb_bus_slave_resp.sv
// tb/tb_bus_slave_resp.sv - self-checking bench for bus_slave_resp
module tb_bus_slave_resp;

  logic        clk;
  logic        reset;
  logic        cs_n    [3];
  logic        as_n    [3];
  logic        rw      [3];
  logic [29:0] addr    [3];
  logic [31:0] wd      [3];
  logic [31:0] rd      [3];
  logic        rdy_n   [3];
  logic        busy    [3];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem   [3][16];
  bit          known [3][16];

  genvar g;
  generate
    for (g = 0; g < 3; g++) begin : g_dut
      bus_slave_resp #(
        .DEPTH       (16),
        .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
      ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .s_cs_     (cs_n[g]),
        .s_as_     (as_n[g]),
        .s_rw      (rw[g]),
        .s_addr    (addr[g]),
        .s_wr_data (wd[g]),
        .s_rd_data (rd[g]),
        .s_rdy_    (rdy_n[g]),
        .busy      (busy[g])
      );
    end
  endgenerate

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int wait_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 1 : 3);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One master transaction on instance k, driven at a negedge. lat is the
  // number of clock edges from driving the request to seeing rdy_ low.
  task automatic txn(input int k, input bit r, input logic [29:0] a,
                     input logic [31:0] d, input bit hold, input int lat);
    int          n;
    bit          seen;
    logic [31:0] exp;
    exp = r ? mem[k][a[3:0]] : 32'h0;
    cs_n[k] = 1'b0; as_n[k] = 1'b0; rw[k] = r; addr[k] = a; wd[k] = d;
    n = 0;
    seen = 1'b0;
    while (!seen && n < lat + 4) begin
      @(negedge clk);
      n++;
      if (n == 1 && lat == 2 + wait_of(k))
        check($sformatf("busy_k%0d", k), 32'(busy[k]), 32'd1);
      if (rdy_n[k] === 1'b0) seen = 1'b1;
    end
    check($sformatf("lat_k%0d_a%0h", k, a), n, lat);
    check($sformatf("data_k%0d_a%0h", k, a), rd[k], exp);
    if (!r) begin
      mem[k][a[3:0]]   = d;
      known[k][a[3:0]] = 1'b1;
    end
    if (!hold) begin
      cs_n[k] = 1'b1; as_n[k] = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] prior;
    bit          saw;
    for (int k = 0; k < 3; k++) begin
      cs_n[k] = 1'b1; as_n[k] = 1'b1; rw[k] = 1'b1; addr[k] = '0; wd[k] = '0;
      for (int i = 0; i < 16; i++) begin
        mem[k][i] = '0; known[k][i] = 1'b0;
      end
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    repeat (10) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check($sformatf("idle_rdy_k%0d", k), 32'(rdy_n[k]), 32'd1);
        check($sformatf("idle_rd_k%0d", k), rd[k], 32'h0);
        check($sformatf("idle_busy_k%0d", k), 32'(busy[k]), 32'd0);
      end
    end

    // Write then read, one wait state
    txn(1, 1'b0, 30'd3, 32'hDEADBEEF, 1'b0, 3);
    txn(1, 1'b1, 30'd3, 32'h0, 1'b0, 3);
    check("rd_deadbeef", mem[1][3], 32'hDEADBEEF);

    // Back-to-back reads with the strobe held, zero wait states: after each
    // ACK one IDLE cycle passes before the held request is taken again.
    for (int i = 0; i < 4; i++) txn(0, 1'b0, 30'(i), $urandom, 1'b0, 2);
    for (int i = 0; i < 4; i++) txn(0, 1'b1, 30'(i), 32'h0, (i < 3), (i == 0) ? 2 : 3);

    // Address aliasing
    txn(1, 1'b0, 30'h13, 32'h12345678, 1'b0, 3);
    txn(1, 1'b1, 30'h3, 32'h0, 1'b0, 3);

    // Abort mid-ACCESS with three wait states
    txn(2, 1'b0, 30'd5, 32'h0BADF00D, 1'b0, 5);
    prior = mem[2][5];
    cs_n[2] = 1'b0; as_n[2] = 1'b0; rw[2] = 1'b0; addr[2] = 30'd5; wd[2] = 32'hA5A5A5A5;
    @(negedge clk);
    check("abort_busy", 32'(busy[2]), 32'd1);
    as_n[2] = 1'b1;
    saw = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rdy_n[2] !== 1'b1) saw = 1'b1;
    end
    check("abort_no_rdy", 32'(saw), 32'd0);
    check("abort_idle", 32'(busy[2]), 32'd0);
    cs_n[2] = 1'b1;
    txn(2, 1'b1, 30'd5, 32'h0, 1'b0, 5);
    check("abort_prior_model", mem[2][5], prior);

    // Reset on the edge that would enter ACK
    txn(1, 1'b0, 30'd7, 32'h7777AAAA, 1'b0, 3);
    cs_n[1] = 1'b0; as_n[1] = 1'b0; rw[1] = 1'b0; addr[1] = 30'd7; wd[1] = 32'hCAFEF00D;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_rdy", 32'(rdy_n[1]), 32'd1);
    check("rst_rd", rd[1], 32'h0);
    check("rst_busy", 32'(busy[1]), 32'd0);
    reset = 1'b0;
    cs_n[1] = 1'b1; as_n[1] = 1'b1;
    @(negedge clk);
    txn(1, 1'b1, 30'd7, 32'h0, 1'b0, 3);

    // Randomized traffic against the bank model
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 25; i++) begin
        logic [29:0] a;
        bit          r;
        a = 30'($urandom);
        r = known[k][a[3:0]] ? 1'($urandom_range(0, 1)) : 1'b0;
        txn(k, r, a, $urandom, 1'b0, 2 + wait_of(k));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
